// File: rtl/noc_input_port_if.sv
`default_nettype none
// ============================================================================
// Module      : noc_input_port_if
// Description : Link/allocator bundle between a router input port and its
//               environment (upstream link, switch allocator, credit return).
// Revision    : 1.0
// ============================================================================
interface noc_input_port_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             grant_i;
    logic [WIDTH-1:0] data_o;
    logic [4:0]       req_o;
    logic             inc_credit_o;
    logic             overflow_o;

    // Environment side: drives the incoming flit and the grant.
    modport master (
        output data_i, valid_i, grant_i,
        input  data_o, req_o, inc_credit_o, overflow_o
    );

    // Input-port side.
    modport slave (
        input  data_i, valid_i, grant_i,
        output data_o, req_o, inc_credit_o, overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/noc_input_port.sv
`default_nettype none
// ============================================================================
// Module      : noc_input_port
// Description : Router input port: DEPTH-entry flit FIFO, XY route of the head
//               flit, switch-allocator request, pop on grant, credit return.
// Revision    : 1.0
// ============================================================================
module noc_input_port #(
    parameter int       WIDTH  = 16,
    parameter int       DEPTH  = 5,
    parameter bit [3:0] X_ADDR = 4'd0,
    parameter bit [3:0] Y_ADDR = 4'd0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    noc_input_port_if.slave   link
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [4:0]       req_q, req_d;
    logic             credit_q, credit_d;
    logic             overflow_q, overflow_d;
    logic             pop, push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // XY routing on the 8 address bits: resolve x first, then y.
    function automatic logic [4:0] route(input logic [7:0] hdr);
        logic [3:0] dx;
        logic [3:0] dy;
        dx = hdr[7:4];
        dy = hdr[3:0];
        if (dx > X_ADDR)      route = 5'b00100;
        else if (dx < X_ADDR) route = 5'b10000;
        else if (dy > Y_ADDR) route = 5'b00010;
        else if (dy < Y_ADDR) route = 5'b01000;
        else                  route = 5'b00001;
    endfunction

    assign pop  = (state_q == REQ) && link.grant_i;
    assign push = link.valid_i && ((count_q < CNT_W'(DEPTH)) || pop);

    always_comb begin
        wr_ptr_d   = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        overflow_d = overflow_q | (link.valid_i & ~push);
        count_d    = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        credit_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    req_d   = route(mem_q[rd_ptr_q][WIDTH-1 -: 8]);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (link.grant_i) begin
                    credit_d = 1'b1;
                    // A flit written on this same edge is not yet visible; it is
                    // picked up from IDLE one edge later.
                    if (count_q > CNT_W'(1)) begin
                        req_d = route(mem_q[next_ptr(rd_ptr_q)][WIDTH-1 -: 8]);
                    end else begin
                        req_d   = 5'b00000;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                req_d   = 5'b00000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            req_q      <= 5'b00000;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            req_q      <= req_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= link.data_i;
        end
    end

    assign link.data_o       = mem_q[rd_ptr_q];
    assign link.req_o        = req_q;
    assign link.inc_credit_o = credit_q;
    assign link.overflow_o   = overflow_q;

endmodule
`default_nettype wire
